grid_access_ctrl: RTL

- Owns the single-port 1-bit trail grid RAM.
- Serialises three requesters onto the one RAM port: the game FSM's per-tick check/mark of both bikes, the clear/border-init sweep, and VGA pixel reads.
- Returns fault/collision flags to the game FSM.
- VGA has absolute priority; engine operations stall around it.

---
 rtl/grid_pkg.sv | 12 +
 rtl/grid_addr_calc.sv | 15 +
 rtl/grid_access_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: shared grid geometry, engine state encoding and border test
package grid_pkg;
    localparam int GRID_SIZE = 50;
    localparam int COORD_W = 6;
    localparam int ADDR_W = 12;

    typedef enum logic [2:0] {IDLE, CLEAR, RD_P1, RD_P2, EVAL, WR_P1, WR_P2, DONE} state_t;

    function automatic logic is_border(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return x == '0 || y == '0 || x == COORD_W'(GRID_SIZE - 1) || y == COORD_W'(GRID_SIZE - 1);
    endfunction
endpackage

// File: rtl/grid_addr_calc.sv
// grid_addr_calc: row-major cell address and range test for one (x,y) pair
//   x, y         : cell coordinates
//   addr         : y*GRID_SIZE + x
//   out_of_range : either coordinate is off the grid
module grid_addr_calc
    import grid_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               out_of_range
);
    assign out_of_range = x >= COORD_W'(GRID_SIZE) || y >= COORD_W'(GRID_SIZE);
    assign addr = ADDR_W'(y) * ADDR_W'(GRID_SIZE) + ADDR_W'(x);
endmodule

// File: rtl/grid_access_ctrl.sv
// grid_access_ctrl: arbitrates the single-port trail grid RAM between VGA, clear sweep and tick check/mark
//   clear_req/clear_busy/clear_done : border-init sweep handshake
//   tick_req, p1_*/p2_*, tick_done  : per-tick check/mark of both bikes
//   p1_fault/p2_fault/both_fault/collision : registered tick results
//   vga_rd_en/vga_x/vga_y -> vga_rd_valid/vga_rd_data : pixel read, one cycle later
//   ram_addr/ram_we/ram_wdata/ram_rdata : RAM port (one-cycle read latency)
module grid_access_ctrl
    import grid_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               clear_done,
    input  logic               tick_req,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    output logic               tick_done,
    output logic               p1_fault,
    output logic               p2_fault,
    output logic               both_fault,
    output logic               collision,
    input  logic               vga_rd_en,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    output logic               vga_rd_valid,
    output logic               vga_rd_data,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic               ram_wdata,
    input  logic               ram_rdata
);
    state_t state, state_n;
    logic [COORD_W-1:0] l1x, l1y, l2x, l2y, sx, sy;
    logic [ADDR_W-1:0] cnt, a1, a2, av;
    logic oor1, oor2, oorv, vga_ok, rd1_d, rd2_d, cell1, cell2;
    logic need, grant, step, last, f1, f2, fb;

    grid_addr_calc u_p1 (.x(l1x), .y(l1y), .addr(a1), .out_of_range(oor1));
    grid_addr_calc u_p2 (.x(l2x), .y(l2y), .addr(a2), .out_of_range(oor2));
    grid_addr_calc u_vga (.x(vga_x), .y(vga_y), .addr(av), .out_of_range(oorv));

    // Only states that actually touch the RAM are stalled by a VGA read;
    // out-of-range reads and EVAL proceed without the port.
    assign need = state == CLEAR || state == WR_P1 || state == WR_P2
                || (state == RD_P1 && !oor1) || (state == RD_P2 && !oor2);
    assign grant = need && !vga_rd_en;
    assign step = grant || !need;
    assign last = cnt == ADDR_W'(GRID_SIZE * GRID_SIZE - 1);

    // p2 data arrives during EVAL itself, so it is used straight off the RAM
    assign f1 = (rd1_d ? ram_rdata : cell1) | oor1;
    assign f2 = (rd2_d ? ram_rdata : cell2) | oor2;
    assign fb = l1x == l2x && l1y == l2y;

    assign ram_addr = vga_rd_en ? av : state == CLEAR ? cnt : (state == RD_P2 || state == WR_P2) ? a2 : a1;
    assign ram_we = !vga_rd_en && (state == CLEAR || state == WR_P1 || state == WR_P2);
    assign ram_wdata = state != CLEAR || is_border(sx, sy);
    assign vga_rd_data = vga_ok & ram_rdata;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = clear_req ? CLEAR : tick_req ? RD_P1 : IDLE;
            CLEAR:   state_n = grant && last ? IDLE : CLEAR;
            RD_P1:   state_n = step ? RD_P2 : RD_P1;
            RD_P2:   state_n = step ? EVAL : RD_P2;
            EVAL:    state_n = f1 || f2 || fb ? DONE : WR_P1;
            WR_P1:   state_n = step ? WR_P2 : WR_P1;
            WR_P2:   state_n = step ? DONE : WR_P2;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            {clear_busy, clear_done, tick_done, vga_rd_valid, vga_ok} <= '0;
            {p1_fault, p2_fault, both_fault, collision} <= '0;
            {rd1_d, rd2_d, cell1, cell2} <= '0;
            {l1x, l1y, l2x, l2y, sx, sy} <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            clear_busy <= state_n == CLEAR;
            tick_done <= state_n == DONE;
            clear_done <= state == CLEAR && grant && last;
            vga_rd_valid <= vga_rd_en;
            vga_ok <= vga_rd_en && !oorv;
            rd1_d <= state == RD_P1 && grant;
            rd2_d <= state == RD_P2 && grant;
            if (rd1_d) cell1 <= ram_rdata;
            if (rd2_d) cell2 <= ram_rdata;
            if (state == IDLE && (clear_req || tick_req)) {p1_fault, p2_fault, both_fault, collision} <= '0;
            if (state == EVAL) {p1_fault, p2_fault, both_fault, collision} <= {f1, f2, fb, f1 | f2 | fb};
            if (state == IDLE && !clear_req && tick_req) {l1x, l1y, l2x, l2y} <= {p1_x, p1_y, p2_x, p2_y};
            if (state == IDLE && clear_req) begin
                cnt <= '0;
                sx <= '0;
                sy <= '0;
            end else if (state == CLEAR && grant) begin
                cnt <= cnt + 1'b1;
                sx <= sx == COORD_W'(GRID_SIZE - 1) ? '0 : sx + 1'b1;
                sy <= sx == COORD_W'(GRID_SIZE - 1) ? sy + 1'b1 : sy;
            end
        end
    end
endmodule
